// File: rtl/gateway_recv_pkg.sv
// Shared route-ID layout and receive-gateway state encoding for the vIO Switch gateways.
package lynxTypes;

  localparam int ROUTE_W    = 14;
  localparam int ID_W       = 4;
  localparam int SENDER_LSB = 6;
  localparam int RECV_LSB   = 2;
  localparam int FLAG_BCAST = 0;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [3:0] sender_id;
    logic [3:0] receiver_id;
    logic [1:0] flags;
  } route_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } gw_rx_state_t;

endpackage

// File: rtl/gateway_recv_route_check.sv
// Combinational route policy: a packet is permitted when its sender is allowed and it is
// addressed to this vFPGA or flagged broadcast.
module gateway_route_check
  import lynxTypes::*;
(
  input  logic [ROUTE_W-1:0] route_id,
  input  logic [ID_W-1:0]    local_id,
  input  logic [15:0]        allow_mask,
  output logic               permit
);

  logic [ID_W-1:0] sender_s;
  logic [ID_W-1:0] recv_s;
  logic            bcast_s;
  logic            unused_s;

  assign sender_s = route_id[SENDER_LSB +: ID_W];
  assign recv_s   = route_id[RECV_LSB +: ID_W];
  assign bcast_s  = route_id[FLAG_BCAST];
  // Reserved route bits and flags[1] carry no policy meaning.
  assign unused_s = ^{route_id[ROUTE_W-1:SENDER_LSB+ID_W], route_id[FLAG_BCAST+1]};

  assign permit = allow_mask[sender_s] & ((recv_s == local_id) | bcast_s);

endmodule

// File: rtl/gateway_recv.sv
// Receive-side routing gateway: forwards permitted packets through one register slice,
// drains all others, and counts accepted/dropped packets with saturating counters.
module gateway_recv
  import lynxTypes::*;
#(
  parameter int DATA_W = 512,
  parameter int CNT_W  = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ID_W-1:0]       local_id,
  input  logic [15:0]           allow_mask,
  input  logic                  stats_clr,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [ROUTE_W-1:0]    s_route_in,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ROUTE_W-1:0]    m_route_out,
  output logic [CNT_W-1:0]      accept_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  gw_rx_state_t        state_r;
  logic [DATA_W-1:0]   tdata_r;
  logic [KEEP_W-1:0]   tkeep_r;
  logic                tlast_r;
  logic                tvalid_r;
  logic [ROUTE_W-1:0]  route_r;
  logic [CNT_W-1:0]    accept_r;
  logic [CNT_W-1:0]    drop_r;

  logic                permit_s;
  logic                ready_s;
  logic                hs_s;
  logic                first_hs_s;
  logic                load_s;

  gateway_route_check u_route_check (
    .route_id   (s_route_in),
    .local_id   (local_id),
    .allow_mask (allow_mask),
    .permit     (permit_s)
  );

  // Ingress ready: draining never waits on egress; otherwise the slice must have room.
  always_comb begin
    ready_s = 1'b0;
    if (areset) begin
      ready_s = 1'b0;
    end else if (state_r == DROP) begin
      ready_s = 1'b1;
    end else begin
      ready_s = ~tvalid_r | m_axis_tready;
    end
  end

  assign hs_s       = s_axis_tvalid & ready_s;
  assign first_hs_s = hs_s & (state_r == IDLE);
  assign load_s     = (first_hs_s & permit_s) | (hs_s & (state_r == PASS));

  // Packet FSM, output register slice and saturating statistics.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r  <= IDLE;
      tdata_r  <= '0;
      tkeep_r  <= '0;
      tlast_r  <= 1'b0;
      tvalid_r <= 1'b0;
      route_r  <= '0;
      accept_r <= '0;
      drop_r   <= '0;
    end else begin
      if (load_s) begin
        tdata_r  <= s_axis_tdata;
        tkeep_r  <= s_axis_tkeep;
        tlast_r  <= s_axis_tlast;
        tvalid_r <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_r <= 1'b0;
      end

      if (first_hs_s & permit_s) begin
        route_r <= s_route_in;
      end

      case (state_r)
        IDLE: begin
          if (hs_s & ~s_axis_tlast) begin
            state_r <= permit_s ? PASS : DROP;
          end
        end
        PASS, DROP: begin
          if (hs_s & s_axis_tlast) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase

      // Clear takes priority over a coincident increment.
      if (stats_clr) begin
        accept_r <= '0;
        drop_r   <= '0;
      end else if (first_hs_s) begin
        if (permit_s && accept_r != CNT_MAX) begin
          accept_r <= accept_r + CNT_ONE;
        end
        if (!permit_s && drop_r != CNT_MAX) begin
          drop_r <= drop_r + CNT_ONE;
        end
      end
    end
  end

  assign s_axis_tready = ready_s;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tkeep  = tkeep_r;
  assign m_axis_tlast  = tlast_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_route_out   = route_r;
  assign accept_cnt    = accept_r;
  assign drop_cnt      = drop_r;

endmodule

// File: tb/tb_gateway_recv.sv
// Directed self-checking bench for gateway_recv with hand-computed expectations.
module tb_gateway_recv;

  localparam int DATA_W = 32;
  localparam int KEEP_W = DATA_W / 8;
  localparam int CNT_W  = 4;

  logic              aclk = 1'b0;
  logic              areset;
  logic [3:0]        local_id;
  logic [15:0]       allow_mask;
  logic              stats_clr;
  logic [DATA_W-1:0] s_axis_tdata;
  logic [KEEP_W-1:0] s_axis_tkeep;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [13:0]       s_route_in;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [13:0]       m_route_out;
  logic [CNT_W-1:0]  accept_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [50:0] out_q[$];
  logic [50:0] exp_q[$];

  gateway_recv #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .areset(areset), .local_id(local_id), .allow_mask(allow_mask),
    .stats_clr(stats_clr), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_route_in(s_route_in), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_route_out(m_route_out), .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  // Egress capture: a transfer seen at the falling edge completes on the next rising edge.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready)
      out_q.push_back({m_route_out, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [13:0] r, output int waited);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_route_in    = r;
    s_axis_tvalid = 1'b1;
    waited = 0;
    @(negedge aclk);
    while (!s_axis_tready && waited < 50) begin
      waited++;
      @(negedge aclk);
    end
    if (!s_axis_tready) check_val("hs_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
  endtask

  task automatic send_pkt(input logic [13:0] r, input int n, input logic [31:0] base,
                          input bit fwd, output int stall);
    int w;
    logic [3:0] k;
    stall = 0;
    for (int i = 0; i < n; i++) begin
      k = (i == n - 1) ? 4'h3 : 4'hF;
      send_beat(base + 32'(i), k, i == n - 1, (i == 0) ? r : 14'h3FFF, w);
      stall += w;
      if (fwd) exp_q.push_back({r, i == n - 1, k, base + 32'(i)});
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic clr_stats();
    stats_clr = 1'b1;
    @(posedge aclk);
    #1;
    stats_clr = 1'b0;
  endtask

  task automatic compare_out(input string tag);
    idle(3);
    check_val({tag, "_beats"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check_val({tag, "_beat"}, 64'(out_q[i]), 64'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int st;
    int w;
    areset = 1'b1; local_id = 4'd3; allow_mask = 16'h0004; stats_clr = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    s_route_in = '0; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_val("rst_tready", 64'(s_axis_tready), 64'd0);
    check_val("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_val("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check_val("rst_route", 64'(m_route_out), 64'd0);
    check_val("rst_acc", 64'(accept_cnt), 64'd0);
    check_val("rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Permitted 4-beat packet: sender 2 -> receiver 3.
    send_pkt(14'h008C, 4, 32'hA000_0000, 1'b1, st);
    compare_out("pass4");
    check_val("pass4_route", 64'(m_route_out), 64'h008C);
    check_val("pass4_acc", 64'(accept_cnt), 64'd1);
    check_val("pass4_drop", 64'(drop_cnt), 64'd0);

    // Same packet, sender not allowed: drained at full rate.
    clr_stats();
    allow_mask = 16'h0001;
    send_pkt(14'h008C, 4, 32'hB000_0000, 1'b0, st);
    check_val("drop4_ready", 64'(st), 64'd0);
    compare_out("drop4");
    check_val("drop4_acc", 64'(accept_cnt), 64'd0);
    check_val("drop4_drop", 64'(drop_cnt), 64'd1);

    // Broadcast to receiver 5 from permitted sender 2.
    clr_stats();
    allow_mask = 16'h0004;
    send_pkt(14'h0095, 2, 32'hC000_0000, 1'b1, st);
    compare_out("bcast");
    check_val("bcast_route", 64'(m_route_out), 64'h0095);
    check_val("bcast_acc", 64'(accept_cnt), 64'd1);

    // Config change after the first beat affects only later packets.
    send_beat(32'hC100_0000, 4'hF, 1'b0, 14'h008C, w);
    allow_mask = 16'h0000;
    local_id = 4'd9;
    send_beat(32'hC100_0001, 4'h3, 1'b1, 14'h3FFF, w);
    exp_q.push_back({14'h008C, 1'b0, 4'hF, 32'hC100_0000});
    exp_q.push_back({14'h008C, 1'b1, 4'h3, 32'hC100_0001});
    compare_out("cfgmid");
    allow_mask = 16'h0004;
    local_id = 4'd3;

    // Egress stall for 5 cycles after the first beat of a 3-beat packet.
    clr_stats();
    m_axis_tready = 1'b0;
    send_beat(32'hD000_0000, 4'hF, 1'b0, 14'h008C, w);
    s_axis_tdata = 32'hD000_0001; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0; s_route_in = 14'h3FFF;
    repeat (5) begin
      @(negedge aclk);
      check_val("stall_valid", 64'(m_axis_tvalid), 64'd1);
      check_val("stall_data", 64'(m_axis_tdata), 64'hD000_0000);
      check_val("stall_ready", 64'(s_axis_tready), 64'd0);
      @(posedge aclk);
      #1;
    end
    m_axis_tready = 1'b1;
    send_beat(32'hD000_0001, 4'hF, 1'b0, 14'h3FFF, w);
    send_beat(32'hD000_0002, 4'h3, 1'b1, 14'h3FFF, w);
    exp_q.push_back({14'h008C, 1'b0, 4'hF, 32'hD000_0000});
    exp_q.push_back({14'h008C, 1'b0, 4'hF, 32'hD000_0001});
    exp_q.push_back({14'h008C, 1'b1, 4'h3, 32'hD000_0002});
    compare_out("stall");
    check_val("stall_acc", 64'(accept_cnt), 64'd1);

    // Back-to-back: drop 2-beat, pass 1-beat, drop 1-beat with no ingress gaps.
    clr_stats();
    w = 0;
    send_pkt(14'h009C, 2, 32'hE000_0000, 1'b0, st); w += st;
    send_pkt(14'h008C, 1, 32'hE100_0000, 1'b1, st); w += st;
    send_pkt(14'h009C, 1, 32'hE200_0000, 1'b0, st); w += st;
    check_val("b2b_gaps", 64'(w), 64'd0);
    compare_out("b2b");
    check_val("b2b_acc", 64'(accept_cnt), 64'd1);
    check_val("b2b_drop", 64'(drop_cnt), 64'd2);

    // Reset after beat 2 of a permitted 4-beat packet.
    send_beat(32'hF000_0000, 4'hF, 1'b0, 14'h008C, w);
    send_beat(32'hF000_0001, 4'hF, 1'b0, 14'h3FFF, w);
    exp_q.push_back({14'h008C, 1'b0, 4'hF, 32'hF000_0000});
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check_val("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_val("mrst_tdata", 64'(m_axis_tdata), 64'd0);
    check_val("mrst_route", 64'(m_route_out), 64'd0);
    check_val("mrst_acc", 64'(accept_cnt), 64'd0);
    check_val("mrst_ready", 64'(s_axis_tready), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    send_pkt(14'h0095, 1, 32'hF100_0000, 1'b1, st);
    compare_out("mrst");
    check_val("mrst_newroute", 64'(m_route_out), 64'h0095);
    check_val("mrst_newacc", 64'(accept_cnt), 64'd1);
    check_val("mrst_newdrop", 64'(drop_cnt), 64'd0);

    // Clear coincident with an accept: clear wins.
    stats_clr = 1'b1;
    send_pkt(14'h008C, 1, 32'hF200_0000, 1'b1, st);
    stats_clr = 1'b0;
    compare_out("clr");
    check_val("clr_acc", 64'(accept_cnt), 64'd0);
    check_val("clr_drop", 64'(drop_cnt), 64'd0);

    // Saturation: 17 dropped packets on a 4-bit counter.
    for (int i = 0; i < 17; i++) send_pkt(14'h009C, 1, 32'h5A00_0000 + 32'(i), 1'b0, st);
    compare_out("sat");
    check_val("sat_drop", 64'(drop_cnt), 64'd15);
    check_val("sat_acc", 64'(accept_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
